// File: rtl/acct_pkg.sv
// rtl/acct_pkg.sv - shared types and constants for the ACCT boot-time configuration master
package acct_pkg;

    localparam int ACCT_ENTRY_W     = 32;
    localparam int ACCT_ADDR_STRIDE = 8;
    localparam int ACCT_IDX_LSB     = 3;
    localparam int ACCT_IDX_MSB     = 10;
    localparam int ACCT_IDX_W       = ACCT_IDX_MSB - ACCT_IDX_LSB + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_LOCK,
        ST_DONE,
        ST_ERR
    } acct_state_e;

    // Byte offset of an entry relative to the table base.
    function automatic logic [63:0] acct_entry_offset(input logic [ACCT_IDX_W-1:0] idx);
        return 64'(idx) * 64'(ACCT_ADDR_STRIDE);
    endfunction

endpackage

// File: rtl/acct_cfg_master_if.sv
// rtl/acct_cfg_master_if.sv - simple register-port bundle between the ACCT master and the ACCT slave
interface acct_cfg_master_if #(
    parameter int AXI_ADDR_WIDTH = 64
);
    logic                      req;
    logic                      we;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [63:0]               wdata;
    logic                      gnt;
    logic [63:0]               rdata;

    modport master (output req, output we, output addr, output wdata, input gnt, input rdata);
    modport slave  (input req, input we, input addr, input wdata, output gnt, output rdata);
endinterface

// File: rtl/acct_cfg_master.sv
// rtl/acct_cfg_master.sv - programs the ACCT table, optional readback (ACCT_CFG_READBACK_EN), then locks it
module acct_cfg_master
    import acct_pkg::*;
#(
    parameter int                      AXI_ADDR_WIDTH = 64,
    parameter int                      NB_ENTRIES     = 3,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                      MAX_RETRY      = 2,
    parameter int                      TIMEOUT_CYCLES = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               start_i,
    input  logic [NB_ENTRIES*ACCT_ENTRY_W-1:0] cfg_entries_i,
    acct_cfg_master_if.master                  bus,
    output logic                               lock_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               err_o,
    output logic [7:0]                         err_idx_o
);

    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int WAIT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ACCT_IDX_W-1:0] LAST_IDX = ACCT_IDX_W'(NB_ENTRIES - 1);

    acct_state_e               state_q, state_d;
    logic [ACCT_IDX_W-1:0]     idx_q, idx_d, nxt_idx;
    logic [RETRY_W-1:0]        retry_q, retry_d;
    logic [WAIT_W-1:0]         wait_q, wait_d;
    logic                      req_q, req_d, we_q, we_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [63:0]               wdata_q, wdata_d;
    logic                      lock_q, lock_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [7:0]                err_idx_q, err_idx_d;
    logic [ACCT_ENTRY_W-1:0]   cur_entry, nxt_entry, first_entry;
    logic                      go_next;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        wait_d      = wait_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lock_d      = lock_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        err_idx_d   = err_idx_q;
        go_next     = 1'b0;
        nxt_idx     = idx_q + 1'b1;
        cur_entry   = cfg_entries_i[ACCT_ENTRY_W*idx_q +: ACCT_ENTRY_W];
        nxt_entry   = cfg_entries_i[ACCT_ENTRY_W*nxt_idx +: ACCT_ENTRY_W];
        first_entry = cfg_entries_i[ACCT_ENTRY_W-1:0];

        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start_i) begin
                    state_d = ST_WR;
                    idx_d   = '0;
                    retry_d = '0;
                    wait_d  = '0;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = BASE_ADDR + AXI_ADDR_WIDTH'(acct_entry_offset('0));
                    wdata_d = {32'b0, first_entry};
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                end
            end
            ST_WR: begin
                if (bus.gnt) begin
                    wait_d = '0;
`ifdef ACCT_CFG_READBACK_EN
                    state_d = ST_RD;
                    we_d    = 1'b0;
`else
                    go_next = 1'b1;
`endif
                end
            end
`ifdef ACCT_CFG_READBACK_EN
            ST_RD: begin
                if (bus.gnt) begin
                    wait_d = '0;
                    if (bus.rdata[ACCT_ENTRY_W-1:0] == cur_entry) begin
                        retry_d = '0;
                        go_next = 1'b1;
                    end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_WR;
                        we_d    = 1'b1;
                    end else begin
                        state_d   = ST_ERR;
                        req_d     = 1'b0;
                        busy_d    = 1'b0;
                        err_d     = 1'b1;
                        err_idx_d = 8'(idx_q);
                    end
                end
            end
`endif
            ST_LOCK: begin
                state_d = ST_DONE;
                lock_d  = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: ;
        endcase

        // A stalled access gives up once it has waited TIMEOUT_CYCLES cycles.
        if (req_q && !bus.gnt && (state_q == ST_WR || state_q == ST_RD)) begin
            if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d   = ST_ERR;
                wait_d    = '0;
                req_d     = 1'b0;
                we_d      = 1'b0;
                busy_d    = 1'b0;
                err_d     = 1'b1;
                err_idx_d = 8'(idx_q);
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end

        if (go_next) begin
            if (idx_q == LAST_IDX) begin
                state_d = ST_LOCK;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end else begin
                state_d = ST_WR;
                idx_d   = nxt_idx;
                req_d   = 1'b1;
                we_d    = 1'b1;
                addr_d  = BASE_ADDR + AXI_ADDR_WIDTH'(acct_entry_offset(nxt_idx));
                wdata_d = {32'b0, nxt_entry};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            retry_q   <= '0;
            wait_q    <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lock_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            wait_q    <= wait_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            lock_q    <= lock_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign bus.req   = req_q;
    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
    assign lock_o    = lock_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign err_idx_o = err_idx_q;

`ifdef ACCT_CFG_READBACK_EN
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^bus.rdata[63:ACCT_ENTRY_W];
`else
    logic unused_rdata;
    assign unused_rdata = ^bus.rdata;
`endif

endmodule

// File: tb/tb_acct_cfg_master.sv
// tb/tb_acct_cfg_master.sv - scoreboard bench for acct_cfg_master
module tb_acct_cfg_master;

`ifdef ACCT_CFG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int   EXP_LAT    = RB ? 8 : 5;
    localparam int   EXP_LAT_D3 = RB ? 26 : 14;
    localparam int   RST_WAIT   = RB ? 3 : 1;
    localparam logic T4_WE      = RB ? 1'b0 : 1'b1;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [95:0] cfg = '0;
    logic        lock_o, busy_o, done_o, err_o;
    logic [7:0]  err_idx_o;
    logic [1:0]  gmode = 2'd0;
    logic        rd_lock = 1'b0;
    logic [31:0] mem [4];
    int          dly = 0;
    int          total = 0;
    int          bad = 0;
    acc_t        exp_q[$];
    acc_t        mon_e;
    logic        pend = 1'b0;
    logic [63:0] prev_addr, prev_wdata;
    logic        prev_we;
    logic [63:0] addr_tab [3];
    logic [31:0] vals [3];
    int          n, cnt;

    acct_cfg_master_if #(.AXI_ADDR_WIDTH(64)) bus_if ();

    acct_cfg_master dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .cfg_entries_i(cfg),
        .bus          (bus_if),
        .lock_o       (lock_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .err_idx_o    (err_idx_o)
    );

    always #5 clk = ~clk;

    // gmode: 0 = gnt tied high, 1 = gnt held low, 2 = gnt after 3 wait cycles.
    assign bus_if.gnt   = (gmode == 2'd0) ? 1'b1 :
                          (gmode == 2'd2) ? (bus_if.req && dly >= 3) : 1'b0;
    assign bus_if.rdata = {32'hDEAD_BEEF,
                           (rd_lock && bus_if.addr[10:3] == 8'd1) ? 32'h0 : mem[bus_if.addr[4:3]]};

    always @(posedge clk) begin
        if (bus_if.req && bus_if.gnt && bus_if.we) mem[bus_if.addr[4:3]] <= bus_if.wdata[31:0];
        if (bus_if.req && !bus_if.gnt) dly <= dly + 1;
        else dly <= 0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_if.req && bus_if.gnt) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_access: got we=%0b addr=%0h want none", bus_if.we, bus_if.addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("acc_we", 64'(bus_if.we), 64'(mon_e.we));
                    chk("acc_addr", bus_if.addr, mon_e.addr);
                    if (mon_e.we) chk("acc_wdata", bus_if.wdata, mon_e.wdata);
                end
            end
            if (pend && bus_if.req) begin
                chk("stable_addr", bus_if.addr, prev_addr);
                chk("stable_we", 64'(bus_if.we), 64'(prev_we));
                chk("stable_wdata", bus_if.wdata, prev_wdata);
            end
            pend       = bus_if.req && !bus_if.gnt;
            prev_addr  = bus_if.addr;
            prev_we    = bus_if.we;
            prev_wdata = bus_if.wdata;
        end else begin
            pend = 1'b0;
        end
    end

    task automatic push_acc(input logic we, input logic [63:0] a, input logic [31:0] d);
        acc_t t;
        t.we    = we;
        t.addr  = a;
        t.wdata = {32'b0, d};
        exp_q.push_back(t);
    endtask

    task automatic push_entry(input int i);
        push_acc(1'b1, addr_tab[i], vals[i]);
`ifdef ACCT_CFG_READBACK_EN
        push_acc(1'b0, addr_tab[i], vals[i]);
`endif
    endtask

    task automatic push_all();
        for (int i = 0; i < 3; i++) push_entry(i);
    endtask

    task automatic set_cfg(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2);
        vals[0] = v0;
        vals[1] = v1;
        vals[2] = v2;
        cfg     = {v2, v1, v0};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic start_pulse();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges from the start assertion until done/err; glitch_at re-pulses start mid-run.
    task automatic start_and_wait(output int cycles, input int glitch_at);
        @(posedge clk);
        #1 start = 1'b1;
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            start = (glitch_at > 0) && (cycles == glitch_at);
        end while (!done_o && !err_o && cycles < 300);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        addr_tab[0] = 64'h0;
        addr_tab[1] = 64'h8;
        addr_tab[2] = 64'h10;
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;

        @(posedge clk);
        #1;
        chk("rst_req", 64'(bus_if.req), 64'd0);
        chk("rst_we", 64'(bus_if.we), 64'd0);
        chk("rst_addr", bus_if.addr, 64'd0);
        chk("rst_wdata", bus_if.wdata, 64'd0);
        chk("rst_lock", 64'(lock_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_err_idx", 64'(err_idx_o), 64'd0);

        // Ideal slave, gnt tied high.
        do_reset();
        gmode = 2'd0;
        set_cfg(32'hA5A5_0001, 32'h0000_0000, 32'hFFFF_0000);
        push_all();
        start_and_wait(n, 0);
        chk("t1_latency", 64'(n), 64'(EXP_LAT));
        chk("t1_lock", 64'(lock_o), 64'd1);
        chk("t1_done", 64'(done_o), 64'd1);
        chk("t1_busy", 64'(busy_o), 64'd0);
        chk("t1_err", 64'(err_o), 64'd0);
        chk("t1_req", 64'(bus_if.req), 64'd0);
        chk("t1_q_empty", 64'(exp_q.size()), 64'd0);

`ifdef ACCT_CFG_READBACK_EN
        // Entry 1 always reads back as zero: three write/read attempts, then error.
        do_reset();
        set_cfg(32'hA5A5_0001, 32'h1234_5678, 32'hFFFF_0000);
        rd_lock = 1'b1;
        push_entry(0);
        repeat (3) push_entry(1);
        start_and_wait(n, 0);
        chk("t2_err", 64'(err_o), 64'd1);
        chk("t2_err_idx", 64'(err_idx_o), 64'd1);
        chk("t2_lock", 64'(lock_o), 64'd0);
        chk("t2_done", 64'(done_o), 64'd0);
        chk("t2_busy", 64'(busy_o), 64'd0);
        chk("t2_req", 64'(bus_if.req), 64'd0);
        chk("t2_q_empty", 64'(exp_q.size()), 64'd0);
        rd_lock = 1'b0;
`endif

        // gnt never arrives: timeout after 16 request cycles, then restart from ERR.
        do_reset();
        set_cfg(32'h1111_2222, 32'h3333_4444, 32'h5555_6666);
        gmode = 2'd1;
        start_pulse();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_if.req) begin
                cnt++;
                if (cnt == 1) chk("t3_addr", bus_if.addr, 64'h0);
            end
            if (err_o) break;
        end
        chk("t3_req_cycles", 64'(cnt), 64'd16);
        chk("t3_err", 64'(err_o), 64'd1);
        chk("t3_err_idx", 64'(err_idx_o), 64'd0);
        chk("t3_req_drop", 64'(bus_if.req), 64'd0);
        chk("t3_lock", 64'(lock_o), 64'd0);
        gmode = 2'd0;
        push_all();
        start_pulse();
        chk("t3_err_clr", 64'(err_o), 64'd0);
        chk("t3_busy", 64'(busy_o), 64'd1);
        cnt = 0;
        while (!done_o && cnt < 50) begin
            @(posedge clk);
            #1 cnt++;
        end
        chk("t3_done", 64'(done_o), 64'd1);
        chk("t3_q_empty", 64'(exp_q.size()), 64'd0);

        // Reset mid-sequence (entry 1 readback, or entry 1 write without readback).
        do_reset();
        set_cfg(32'hCAFE_0000, 32'h0BAD_F00D, 32'h0000_0007);
        push_all();
        start_pulse();
        repeat (RST_WAIT) @(posedge clk);
        #2;
        chk("t4_pre_req", 64'(bus_if.req), 64'd1);
        chk("t4_pre_we", 64'(bus_if.we), 64'(T4_WE));
        chk("t4_pre_addr", bus_if.addr, 64'h8);
        rst_n = 1'b0;
        #1;
        chk("t4_req_async", 64'(bus_if.req), 64'd0);
        chk("t4_addr_rst", bus_if.addr, 64'd0);
        chk("t4_busy_rst", 64'(busy_o), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        push_all();
        start_and_wait(n, 0);
        chk("t4_latency", 64'(n), 64'(EXP_LAT));
        chk("t4_done", 64'(done_o), 64'd1);
        chk("t4_q_empty", 64'(exp_q.size()), 64'd0);

        // start_i pulses while busy and while in DONE are ignored.
        do_reset();
        set_cfg(32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFF);
        push_all();
        start_and_wait(n, 2);
        chk("t5_latency", 64'(n), 64'(EXP_LAT));
        chk("t5_done", 64'(done_o), 64'd1);
        start_pulse();
        repeat (5) @(posedge clk);
        #1;
        chk("t5_done_hold", 64'(done_o), 64'd1);
        chk("t5_busy", 64'(busy_o), 64'd0);
        chk("t5_req", 64'(bus_if.req), 64'd0);
        chk("t5_lock", 64'(lock_o), 64'd1);
        chk("t5_q_empty", 64'(exp_q.size()), 64'd0);

        // gnt after 3 wait cycles on every access.
        do_reset();
        gmode = 2'd2;
        set_cfg(32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98);
        push_all();
        start_and_wait(n, 0);
        chk("t6_latency", 64'(n), 64'(EXP_LAT_D3));
        chk("t6_done", 64'(done_o), 64'd1);
        chk("t6_err", 64'(err_o), 64'd0);
        chk("t6_q_empty", 64'(exp_q.size()), 64'd0);
        gmode = 2'd0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
